// File: rtl/inspection_pkg.sv
// Shared encodings for the inspection (E) and protocol (Y) FSMs and the reject-gate state.
package inspection_pkg;

  typedef enum logic [1:0] {
    E_IDLE    = 2'b00,
    E_INSPECT = 2'b01,
    E_ACCEPT  = 2'b10,
    E_REJECT  = 2'b11
  } e_state_t;

  typedef enum logic [1:0] {
    Y_NONE   = 2'b00,
    Y_CONVEY = 2'b01,
    Y_DIVERT = 2'b10,
    Y_HALT   = 2'b11
  } y_act_t;

  typedef enum logic [1:0] {
    G_IDLE    = 2'b00,
    G_FIRE    = 2'b01,
    G_HOLDOFF = 2'b10
  } g_state_t;

endpackage

// File: rtl/reject_gate_fsm.sv
// Reject-gate pulse generator: fires a fixed-length gate pulse on each DIVERT edge,
// then holds off; DIVERT edges while busy are dropped and flagged on drop_c.
module reject_gate_fsm
  import inspection_pkg::*;
#(
  parameter int unsigned GATE_CYCLES    = 4,
  parameter int unsigned HOLDOFF_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] y_in,
  output logic       gate_o,
  output logic       busy_o,
  output logic       drop_c
);

  localparam int unsigned GC_MAX = (GATE_CYCLES > HOLDOFF_CYCLES) ? GATE_CYCLES : HOLDOFF_CYCLES;
  localparam int unsigned GC_W   = (GC_MAX > 1) ? $clog2(GC_MAX) : 1;

  g_state_t        state_q, state_d;
  logic [GC_W-1:0] gcnt_q, gcnt_d;
  logic [1:0]      y_prev;
  logic            div_ev;

  assign div_ev = (y_in == Y_DIVERT) && (y_prev != Y_DIVERT);

  // Next-state, down-counter and drop detection; HALT overrides everything
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    drop_c  = 1'b0;
    if (y_in == Y_HALT) begin
      state_d = G_IDLE;
      gcnt_d  = '0;
    end else begin
      case (state_q)
        G_IDLE: begin
          if (div_ev) begin
            state_d = G_FIRE;
            gcnt_d  = GC_W'(GATE_CYCLES - 1);
          end
        end
        G_FIRE: begin
          drop_c = div_ev;
          if (gcnt_q == '0) begin
            state_d = G_HOLDOFF;
            gcnt_d  = GC_W'(HOLDOFF_CYCLES - 1);
          end else begin
            gcnt_d = gcnt_q - GC_W'(1);
          end
        end
        G_HOLDOFF: begin
          drop_c = div_ev;
          if (gcnt_q == '0) begin
            state_d = G_IDLE;
          end else begin
            gcnt_d = gcnt_q - GC_W'(1);
          end
        end
        default: begin
          state_d = G_IDLE;
          gcnt_d  = '0;
        end
      endcase
    end
  end

  // State, counter, edge register and registered gate/busy outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= G_IDLE;
      gcnt_q  <= '0;
      y_prev  <= Y_NONE;
      gate_o  <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      y_prev  <= y_in;
      gate_o  <= (state_d == G_FIRE);
      busy_o  <= (state_d != G_IDLE);
    end
  end

endmodule

// File: rtl/inspection_tally.sv
// Verdict tally: counts accept/reject edges, raises a sticky alarm after a run of
// consecutive rejects, and drives the reject gate from DIVERT requests.
module inspection_tally
  import inspection_pkg::*;
#(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned GATE_CYCLES    = 4,
  parameter int unsigned HOLDOFF_CYCLES = 2,
  parameter int unsigned ALARM_LIMIT    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       e_in,
  input  logic [1:0]       y_in,
  input  logic             clr_i,
  input  logic             sel_i,
  output logic [CNT_W-1:0] count_o,
  output logic             gate_o,
  output logic             busy_o,
  output logic             alarm_o,
  output logic             miss_o
);

  localparam int unsigned RUN_W = (ALARM_LIMIT > 1) ? $clog2(ALARM_LIMIT + 1) : 1;

  logic [1:0]       e_prev;
  logic [CNT_W-1:0] pass_cnt, rej_cnt;
  logic [RUN_W-1:0] run_q, run_d;
  logic             acc_ev, rej_ev, drop_c;

  assign acc_ev = (e_in == E_ACCEPT) && (e_prev != E_ACCEPT);
  assign rej_ev = (e_in == E_REJECT) && (e_prev != E_REJECT);

  reject_gate_fsm #(
    .GATE_CYCLES   (GATE_CYCLES),
    .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
  ) u_gate (
    .clk   (clk),
    .rst_n (rst),
    .y_in  (y_in),
    .gate_o(gate_o),
    .busy_o(busy_o),
    .drop_c(drop_c)
  );

  // Consecutive-reject run: accept restarts it, rejects climb to the limit and stop
  always_comb begin
    run_d = run_q;
    if (acc_ev) begin
      run_d = '0;
    end else if (rej_ev && (run_q != RUN_W'(ALARM_LIMIT))) begin
      run_d = run_q + RUN_W'(1);
    end
  end

  // Saturating counters, sticky alarm and miss flag; clear wins over same-cycle events
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_prev   <= E_IDLE;
      pass_cnt <= '0;
      rej_cnt  <= '0;
      run_q    <= '0;
      alarm_o  <= 1'b0;
      miss_o   <= 1'b0;
    end else begin
      e_prev <= e_in;
      if (clr_i) begin
        pass_cnt <= '0;
        rej_cnt  <= '0;
        run_q    <= '0;
        alarm_o  <= 1'b0;
        miss_o   <= 1'b0;
      end else begin
        if (acc_ev && (pass_cnt != '1)) pass_cnt <= pass_cnt + CNT_W'(1);
        if (rej_ev && (rej_cnt != '1))  rej_cnt  <= rej_cnt + CNT_W'(1);
        run_q   <= run_d;
        alarm_o <= alarm_o | (run_d == RUN_W'(ALARM_LIMIT));
        miss_o  <= miss_o | drop_c;
      end
    end
  end

  // Counter readback select
  always_comb begin
    count_o = sel_i ? rej_cnt : pass_cnt;
  end

endmodule
